// File: rtl/term_vram_writer_if.sv
// ---------------------------------------------------------------------------
// term_vram_writer_if
// Byte-stream handshake between the UART RX path and the terminal writer.
//   in_valid  source -> sink  byte available
//   in_data   source -> sink  byte value
//   in_attr   source -> sink  attribute bit stored as cell bit 8
//   in_ready  sink -> source  sink accepts a byte this cycle
// A byte transfers on a clock edge where in_valid && in_ready. The source
// must hold in_data/in_attr stable while in_valid is high and in_ready low.
// ---------------------------------------------------------------------------
interface term_vram_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_attr;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_attr,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_attr,
    output in_ready
  );
endinterface

// File: rtl/term_vram_writer.sv
// ---------------------------------------------------------------------------
// term_vram_writer
// Character-stream front end of the serial terminal. Accepts received bytes,
// interprets control codes, tracks the cursor and writes 9-bit cells
// {attr, char} into port A of the 64x32 text VRAM. Scrolling is done in
// hardware: scroll_row is the physical VRAM row shown as logical row 0, so a
// scroll only needs one 64-cell line clear.
//
// Ports
//   clk         system clock (shared with VRAM port A)
//   rst_n       asynchronous active-low reset
//   in_if       byte-stream handshake (slave side: in_valid/in_data/in_attr
//               in, in_ready out; in_ready high only in IDLE)
//   vram_addr   {phys_row[4:0], col[5:0]} to VRAM port A (registered)
//   vram_din    {attr, char} to VRAM port A (registered)
//   vram_ce     port A clock enable, one-cycle strobe (registered)
//   vram_we     port A write enable, identical to vram_ce
//   cursor_col  cursor column 0..63
//   cursor_row  logical cursor row 0..31
//   scroll_row  physical VRAM row displayed as logical row 0
//   busy        a line or full-screen clear is in progress
//
// Parameters
//   BLANK_CHAR      character written by clears (attribute bit 0)
//   CLEAR_ON_RESET  1: clear the whole screen after reset, 0: start in IDLE
//
// Build option
//   TERM_TAB_EN     when defined, 0x09 advances to the next multiple of 8
//                   (wrapping with a line feed from col >= 56); otherwise
//                   0x09 is consumed with no effect.
// ---------------------------------------------------------------------------
module term_vram_writer #(
  parameter logic [7:0] BLANK_CHAR     = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  term_vram_writer_if.slave         in_if,
  output logic [10:0]               vram_addr,
  output logic [8:0]                vram_din,
  output logic                      vram_ce,
  output logic                      vram_we,
  output logic [5:0]                cursor_col,
  output logic [4:0]                cursor_row,
  output logic [4:0]                scroll_row,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1,
    CLEAR_ALL  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
  localparam logic [8:0] BLANK_CELL = {1'b0, BLANK_CHAR};

  state_t      state, state_nxt;
  logic [10:0] clr_cnt, clr_cnt_nxt;
  logic [5:0]  col_nxt;
  logic [4:0]  row_nxt;
  logic [4:0]  scroll_nxt;
  logic [10:0] addr_nxt;
  logic [8:0]  din_nxt;
  logic        ce_nxt;
  logic        do_lf;
  logic        in_ready;
  logic        accept;
  logic [4:0]  phys_row;
  logic [7:0]  byte_in;
  logic        is_printable;

  assign in_ready       = (state == IDLE);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign byte_in        = in_if.in_data;
  assign is_printable   = (byte_in >= 8'h20) && (byte_in <= 8'h7E);
  assign busy           = (state != IDLE);
  assign vram_we        = vram_ce;

  // Physical row wraps mod 32 through the 5-bit add. During CLEAR_LINE the
  // cursor sits on logical row 31 and scroll_row has already advanced, so
  // this lands on the old scroll_row -- exactly the row that just became the
  // new bottom line.
  assign phys_row = cursor_row + scroll_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      clr_cnt    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      scroll_row <= '0;
      vram_addr  <= '0;
      vram_din   <= '0;
      vram_ce    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      cursor_col <= col_nxt;
      cursor_row <= row_nxt;
      scroll_row <= scroll_nxt;
      vram_addr  <= addr_nxt;
      vram_din   <= din_nxt;
      vram_ce    <= ce_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    col_nxt     = cursor_col;
    row_nxt     = cursor_row;
    scroll_nxt  = scroll_row;
    addr_nxt    = vram_addr;
    din_nxt     = vram_din;
    ce_nxt      = 1'b0;
    do_lf       = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_printable) begin
            // Write lands at the pre-advance cursor position.
            addr_nxt = {phys_row, cursor_col};
            din_nxt  = {in_if.in_attr, byte_in};
            ce_nxt   = 1'b1;
            if (cursor_col == 6'd63) begin
              col_nxt = 6'd0;
              do_lf   = 1'b1;
            end else begin
              col_nxt = cursor_col + 6'd1;
            end
          end else if (byte_in == 8'h0D) begin
            col_nxt = 6'd0;
          end else if (byte_in == 8'h0A) begin
            do_lf = 1'b1;
          end else if (byte_in == 8'h08) begin
            if (cursor_col != 6'd0) begin
              col_nxt = cursor_col - 6'd1;
            end
          end else if (byte_in == 8'h0C) begin
            col_nxt     = 6'd0;
            row_nxt     = 5'd0;
            scroll_nxt  = 5'd0;
            clr_cnt_nxt = '0;
            state_nxt   = CLEAR_ALL;
`ifdef TERM_TAB_EN
          end else if (byte_in == 8'h09) begin
            if (cursor_col >= 6'd56) begin
              col_nxt = 6'd0;
              do_lf   = 1'b1;
            end else begin
              col_nxt = {cursor_col[5:3] + 3'd1, 3'b000};
            end
`endif
          end

          // Line feed: move down, or scroll by advancing the display origin
          // and blanking the row that becomes the new bottom line.
          if (do_lf) begin
            if (cursor_row != 5'd31) begin
              row_nxt = cursor_row + 5'd1;
            end else begin
              scroll_nxt  = scroll_row + 5'd1;
              clr_cnt_nxt = '0;
              state_nxt   = CLEAR_LINE;
            end
          end
        end
      end

      CLEAR_LINE: begin
        addr_nxt    = {phys_row, clr_cnt[5:0]};
        din_nxt     = BLANK_CELL;
        ce_nxt      = 1'b1;
        clr_cnt_nxt = clr_cnt + 11'd1;
        if (clr_cnt[5:0] == 6'd63) begin
          state_nxt = IDLE;
        end
      end

      CLEAR_ALL: begin
        addr_nxt    = clr_cnt;
        din_nxt     = BLANK_CELL;
        ce_nxt      = 1'b1;
        clr_cnt_nxt = clr_cnt + 11'd1;
        if (clr_cnt == 11'd2047) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
